// File: rtl/uart_pkg.sv
// Shared UART definitions: ASCII constants, line length, FSM state encodings
// and the BCD-digit-to-ASCII conversion used by the score reporter.
package uart_pkg;

    localparam logic [7:0] ZERO  = 8'h30;
    localparam logic [7:0] DASH  = 8'h2D;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] QMARK = 8'h3F;

    localparam int FRAME_BYTES = 7;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        LINE_IDLE,
        LINE_LOAD,
        LINE_SEND_BYTE,
        LINE_WAIT_BYTE
    } line_state_t;

    // Non-BCD codes (10..15) are reported as '?' so a corrupt counter is visible on the host.
    function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
        return (d <= 4'd9) ? (ZERO + {4'd0, d}) : QMARK;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, eight data bits LSB first, stop bit,
// each held for CLKS_PER_BIT cycles. RsTx-style output is registered.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready,
    output logic       byte_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state;
    tx_state_t        next_state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic [7:0]       shift_next;
    logic             tx_next;
    logic             bit_end;

    assign bit_end   = (baud_cnt == LAST_CNT);
    assign ready     = (state == TX_IDLE);
    assign byte_done = (state == TX_STOP) && bit_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= TX_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        shift_next = shift;
        tx_next    = 1'b1;
        case (state)
            TX_IDLE: begin
                if (start) begin
                    next_state = TX_START;
                    shift_next = data;
                end
            end
            TX_START: begin
                if (bit_end) next_state = TX_DATA;
            end
            TX_DATA: begin
                if (bit_end) begin
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) next_state = TX_STOP;
                end
            end
            TX_STOP: begin
                if (bit_end) next_state = TX_IDLE;
            end
            default: next_state = TX_IDLE;
        endcase
        // The line level follows the state being entered so tx stays a clean register output.
        case (next_state)
            TX_START: tx_next = 1'b0;
            TX_DATA:  tx_next = shift_next[0];
            default:  tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
            tx       <= 1'b1;
        end else begin
            tx    <= tx_next;
            shift <= shift_next;
            if (state == TX_IDLE) begin
                baud_cnt <= '0;
                bit_idx  <= 3'd0;
            end else begin
                baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
                if (state == TX_DATA && bit_end) begin
                    bit_idx <= bit_idx + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/score_uart_tx.sv
// Score reporter: on a send pulse, snapshots the four BCD score digits and
// transmits the ASCII line "P1P1-P2P2\r\n" through the byte serializer.
module score_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [3:0] dig0,
    input  logic [3:0] dig1,
    input  logic [3:0] dig2,
    input  logic [3:0] dig3,
    output logic       busy,
    output logic       done,
    output logic       RsTx
);

    line_state_t state;
    line_state_t next_state;
    logic [3:0]  snap0;
    logic [3:0]  snap1;
    logic [3:0]  snap2;
    logic [3:0]  snap3;
    logic [2:0]  byte_idx;
    logic [7:0]  tx_byte;
    logic        ser_start;
    logic        ser_ready;
    logic        ser_done;
    logic        last_byte;

    assign busy      = (state != LINE_IDLE);
    assign last_byte = (byte_idx == 3'(FRAME_BYTES - 1));
    assign ser_start = (state == LINE_LOAD) && ser_ready;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk      (clk),
        .reset    (reset),
        .start    (ser_start),
        .data     (tx_byte),
        .tx       (RsTx),
        .ready    (ser_ready),
        .byte_done(ser_done)
    );

    // Tens digit goes first so the host reads each score in natural order.
    always_comb begin
        tx_byte = LF;
        case (byte_idx)
            3'd0:    tx_byte = digit_to_ascii(snap1);
            3'd1:    tx_byte = digit_to_ascii(snap0);
            3'd2:    tx_byte = DASH;
            3'd3:    tx_byte = digit_to_ascii(snap3);
            3'd4:    tx_byte = digit_to_ascii(snap2);
            3'd5:    tx_byte = CR;
            default: tx_byte = LF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LINE_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            LINE_IDLE: begin
                if (send) next_state = LINE_LOAD;
            end
            LINE_LOAD: begin
                if (ser_ready) next_state = LINE_WAIT_BYTE;
            end
            LINE_WAIT_BYTE: begin
                if (ser_done) next_state = last_byte ? LINE_IDLE : LINE_LOAD;
            end
            default: next_state = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            snap0    <= 4'd0;
            snap1    <= 4'd0;
            snap2    <= 4'd0;
            snap3    <= 4'd0;
            byte_idx <= 3'd0;
            done     <= 1'b0;
        end else begin
            done <= (state == LINE_WAIT_BYTE) && ser_done && last_byte;
            if (state == LINE_IDLE && send) begin
                snap0    <= dig0;
                snap1    <= dig1;
                snap2    <= dig2;
                snap3    <= dig3;
                byte_idx <= 3'd0;
            end else if (state == LINE_WAIT_BYTE && ser_done && !last_byte) begin
                byte_idx <= byte_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_score_uart_tx.sv
// Self-checking bench for score_uart_tx at 16 clocks per bit: table-driven
// score lines plus hand-written abort and back-to-back sequences.
module tb_score_uart_tx;

    localparam int CPB = 16;

    typedef logic [6:0][7:0] line_t;

    typedef struct {
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
        logic [3:0] d3;
        logic       disturb;
        line_t      exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       send;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [3:0] dig2;
    logic [3:0] dig3;
    logic       busy;
    logic       done;
    logic       RsTx;

    int nChecks = 0;
    int nFails  = 0;

    vec_t vecs[4];

    always #5 clk = ~clk;

    score_uart_tx #(
        .CLK_FREQ(16),
        .BAUD    (1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .send (send),
        .dig0 (dig0),
        .dig1 (dig1),
        .dig2 (dig2),
        .dig3 (dig3),
        .busy (busy),
        .done (done),
        .RsTx (RsTx)
    );

    function automatic line_t mkLine(input logic [7:0] b0, input logic [7:0] b1,
                                     input logic [7:0] b2, input logic [7:0] b3,
                                     input logic [7:0] b4, input logic [7:0] b5,
                                     input logic [7:0] b6);
        return {b6, b5, b4, b3, b2, b1, b0};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called at a falling edge; the next rising edge samples send, and the
    // following falling edge must show the LOAD cycle (busy high, line idle).
    task automatic applyStimulus(input vec_t v);
        dig0 = v.d0;
        dig1 = v.d1;
        dig2 = v.d2;
        dig3 = v.d3;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        checkOutput("busy_after_send", 32'(busy), 32'd1);
        checkOutput("load_cycle_idle", 32'(RsTx), 32'd1);
    endtask

    // Walks the full expected waveform of one line and ends on the done cycle.
    task automatic checkLine(input line_t exp, input logic disturb);
        int   waveErr = 0;
        int   busyErr = 0;
        int   doneErr = 0;
        int   cyc = 0;
        logic expBit;
        logic [7:0] got;
        for (int k = 0; k < 7; k++) begin
            got = 8'd0;
            for (int b = 0; b < 10; b++) begin
                for (int c = 0; c < CPB; c++) begin
                    @(negedge clk);
                    cyc++;
                    if (disturb) begin
                        if (cyc == 1) begin
                            dig0 = 4'd9; dig1 = 4'd9; dig2 = 4'd9; dig3 = 4'd9;
                        end
                        if (cyc == 300) send = 1'b1;
                        else if (cyc == 301) send = 1'b0;
                    end
                    if (b == 0) expBit = 1'b0;
                    else if (b == 9) expBit = 1'b1;
                    else expBit = exp[k][b-1];
                    if (k == 0 && b == 0 && c == 0)
                        checkOutput("first_start_bit", 32'(RsTx), 32'd0);
                    if (RsTx !== expBit) waveErr++;
                    if (busy !== 1'b1) busyErr++;
                    if (done !== 1'b0) doneErr++;
                    if (c == CPB / 2 && b >= 1 && b <= 8) got[b-1] = RsTx;
                end
            end
            checkOutput($sformatf("byte%0d", k), 32'(got), 32'(exp[k]));
            if (k < 6) begin
                @(negedge clk);
                if (RsTx !== 1'b1) waveErr++;
                if (busy !== 1'b1) busyErr++;
                if (done !== 1'b0) doneErr++;
            end
        end
        checkOutput("wave_error_cycles", 32'(waveErr), 32'd0);
        checkOutput("busy_low_in_line", 32'(busyErr), 32'd0);
        checkOutput("done_early", 32'(doneErr), 32'd0);
        @(negedge clk);
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("busy_at_done", 32'(busy), 32'd0);
        checkOutput("idle_at_done", 32'(RsTx), 32'd1);
    endtask

    task automatic checkQuiet(input int n, input string name);
        int txErr = 0;
        int busyErr = 0;
        int doneErr = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (RsTx !== 1'b1) txErr++;
            if (busy !== 1'b0) busyErr++;
            if (done !== 1'b0) doneErr++;
        end
        checkOutput({name, "_tx"}, 32'(txErr), 32'd0);
        checkOutput({name, "_busy"}, 32'(busyErr), 32'd0);
        checkOutput({name, "_done"}, 32'(doneErr), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{d0: 4'd2, d1: 4'd1, d2: 4'd3, d3: 4'd0, disturb: 1'b0,
                    exp: mkLine(8'h31, 8'h32, 8'h2D, 8'h30, 8'h33, 8'h0D, 8'h0A)};
        vecs[1] = '{d0: 4'd2, d1: 4'd1, d2: 4'd3, d3: 4'd0, disturb: 1'b1,
                    exp: mkLine(8'h31, 8'h32, 8'h2D, 8'h30, 8'h33, 8'h0D, 8'h0A)};
        vecs[2] = '{d0: 4'hA, d1: 4'd0, d2: 4'hF, d3: 4'd0, disturb: 1'b0,
                    exp: mkLine(8'h30, 8'h3F, 8'h2D, 8'h30, 8'h3F, 8'h0D, 8'h0A)};
        vecs[3] = '{d0: 4'd9, d1: 4'd9, d2: 4'd7, d3: 4'd5, disturb: 1'b0,
                    exp: mkLine(8'h39, 8'h39, 8'h2D, 8'h35, 8'h37, 8'h0D, 8'h0A)};

        reset = 1'b1;
        send  = 1'b0;
        dig0  = 4'd0;
        dig1  = 4'd0;
        dig2  = 4'd0;
        dig3  = 4'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", 32'(RsTx), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        reset = 1'b0;
        checkQuiet(100, "idle");

        for (int i = 0; i < 4; i++) begin
            $display("[TB] line vector %0d", i);
            applyStimulus(vecs[i]);
            checkLine(vecs[i].exp, vecs[i].disturb);
            checkQuiet(20, $sformatf("post_line%0d", i));
        end

        $display("[TB] reset during byte 3 data bits");
        applyStimulus(vecs[0]);
        repeat (1 + 3 * (10 * CPB + 1) + CPB + 40) @(negedge clk);
        checkOutput("pre_abort_busy", 32'(busy), 32'd1);
        checkOutput("pre_abort_data_bit", 32'(RsTx), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_tx", 32'(RsTx), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        reset = 1'b0;
        checkQuiet(200, "after_abort");
        applyStimulus(vecs[3]);
        checkLine(vecs[3].exp, 1'b0);
        checkQuiet(20, "post_abort_line");

        $display("[TB] send in the done cycle");
        applyStimulus(vecs[0]);
        checkLine(vecs[0].exp, 1'b0);
        applyStimulus(vecs[3]);
        checkLine(vecs[3].exp, 1'b0);
        checkQuiet(20, "post_chain");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
